// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide, with sign fix-up and single-cycle fast paths for divide corner cases.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [TAG_WIDTH-1:0]  TagIn,
    input  logic                  Flush,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] Result,
    output logic [TAG_WIDTH-1:0]  TagOut,
    output logic                  Busy,
    output logic [1:0]            dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0]  ONE   = W'(1);
    localparam logic [PW-1:0] ONE2  = PW'(1);
    localparam logic [W-1:0]  MINV  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST  = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // InValid/InReady move an op in; OutValid/OutReady move a result out; Flush overrides both.
    state_t          state;
    logic [2:0]      op;
    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            neg_res;
    logic            a_neg_q;
    logic [CW-1:0]   counter;
    logic [PW-1:0]   prod;

    logic            a_signed, b_signed, a_neg_in, b_neg_in;
    logic [W-1:0]    a_mag_in, b_mag_in;
    logic            div_zero, div_ovf, fast_hit;
    logic [W-1:0]    fast_val;
    logic [W:0]      mul_sum, div_shift, div_diff;
    logic [PW-1:0]   prod_step, prod_s;
    logic [W-1:0]    quo, rem, fix_val;

    assign InReady   = (state == IDLE);
    assign Busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        a_signed = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        b_signed = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        a_neg_in = a_signed & SrcA[W-1];
        b_neg_in = b_signed & SrcB[W-1];
        a_mag_in = a_neg_in ? (~SrcA + ONE) : SrcA;
        b_mag_in = b_neg_in ? (~SrcB + ONE) : SrcB;

        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == MINV) && (SrcB == '1);
        fast_hit = div_zero || div_ovf;
        if (div_zero) fast_val = Funct3[1] ? SrcA : '1;
        else          fast_val = Funct3[1] ? '0 : SrcA;
    end

    // Product register doubles as {remainder, quotient/dividend} during a divide.
    always_comb begin
        mul_sum   = {1'b0, prod[PW-1:W]} + (prod[0] ? {1'b0, b_mag} : '0);
        div_shift = {prod[PW-1:W], prod[W-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        if (!op[2])         prod_step = {mul_sum, prod[W-1:1]};
        else if (div_diff[W]) prod_step = {div_shift[W-1:0], prod[W-2:0], 1'b0};
        else                prod_step = {div_diff[W-1:0], prod[W-2:0], 1'b1};
    end

    always_comb begin
        prod_s = neg_res ? (~prod + ONE2) : prod;
        quo    = prod[W-1:0];
        rem    = prod[PW-1:W];
        if (op[2]) begin
            if (op[1]) fix_val = a_neg_q ? (~rem + ONE) : rem;
            else       fix_val = neg_res ? (~quo + ONE) : quo;
        end else begin
            fix_val = (op[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[PW-1:W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op       <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            neg_res  <= 1'b0;
            a_neg_q  <= 1'b0;
            counter  <= '0;
            prod     <= '0;
            Result   <= '0;
            TagOut   <= '0;
            OutValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid && !Flush) begin
                        op      <= Funct3;
                        TagOut  <= TagIn;
                        a_mag   <= a_mag_in;
                        b_mag   <= b_mag_in;
                        neg_res <= a_neg_in ^ b_neg_in;
                        a_neg_q <= a_neg_in;
                        counter <= '0;
                        prod    <= {{W{1'b0}}, a_mag_in};
                        if (fast_hit) begin
                            Result   <= fast_val;
                            OutValid <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else begin
                        prod    <= prod_step;
                        counter <= counter + CW'(1);
                        if (counter == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else begin
                        Result   <= fix_val;
                        OutValid <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (Flush || OutReady) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, parametrised in operand width.
- Sits beside the ALU in the datapath. Accepts one M-extension operation via a valid/ready handshake and returns a tagged result via a second valid/ready handshake.
- Lets the core stall on long-latency ops instead of computing them combinationally.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be ≥4 and even.
- TAG_WIDTH, 5, width of the destination-register tag carried with each op.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- InValid  in  1  operation request.
- InReady  out  1  unit can accept a request.
- Funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  in  DATA_WIDTH  rs1 operand.
- SrcB  in  DATA_WIDTH  rs2 operand.
- TagIn  in  TAG_WIDTH  destination tag.
- Flush  in  1  synchronous abort of the in-flight op.
- OutValid  out  1  result available.
- OutReady  in  1  consumer takes the result.
- Result  out  DATA_WIDTH  result value.
- TagOut  out  TAG_WIDTH  tag of the result.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (rst=0, asynchronous): state=IDLE, counter=0, all datapath registers=0, Result=0, TagOut=0, OutValid=0, Busy=0. InReady=1 once rst is released.
- Reset asserted mid-operation discards the op; no result is produced.
- InReady = (state==IDLE).
- Accept edge: InValid & InReady. On this edge the unit latches Funct3, SrcA, SrcB, TagIn.
  - Operands are converted to magnitudes per signedness: MUL/MULH/DIV/REM treat both signed; MULHSU treats A signed, B unsigned; MULHU/DIVU/REMU treat both unsigned.
  - The result sign is recorded.
- Fast path (evaluated at the accept edge, next state DONE):
  - DIV/DIVU with B=0: quotient = all ones.
  - REM/REMU with B=0: remainder = A.
  - DIV with A = most negative and B = −1: quotient = A.
  - REM with A = most negative and B = −1: remainder = 0.
- Otherwise the next state is CALC with counter=0.
- CALC, one bit per edge, counter increments, exactly DATA_WIDTH edges, then FIX:
  - Multiply: radix-2 shift-add into a 2·DATA_WIDTH product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX (1 edge), negate where required:
  - Product: negate if the sign bits differ.
  - Quotient: negate if the dividend and divisor signs differ.
  - Remainder: takes the sign of the dividend.
  - Result selection: MUL takes the low half of the product; MULH/MULHSU/MULHU take the high half.
  - Next state DONE.
- DONE: OutValid=1. Result and TagOut are held stable until OutReady=1; that edge returns the unit to IDLE and clears OutValid.
- Latency: OutValid rises DATA_WIDTH+2 edges after the accept edge (34 for DATA_WIDTH=32); fast path rises 1 edge after.
- Throughput: no accept while in DONE, even if OutReady=1 in the same cycle. A new op can be accepted at the earliest the cycle after the DONE→IDLE edge.
- Flush=1 at any edge in CALC/FIX/DONE: next state IDLE, OutValid=0, result discarded.
- Flush in IDLE: the request in that cycle is not accepted, even if InValid=1.
- Flush has priority over OutReady and over completion.
- All arithmetic is modulo 2^DATA_WIDTH per half. Negation of the most negative value wraps to itself.
- Inputs other than handshake and Flush are ignored outside the accept edge. Changes to SrcA/SrcB during CALC have no effect.

Test Plan:
- MUL 7 × 0xFFFFFFFD, tag 3 → OutValid after 34 edges, Result=0xFFFFFFEB, TagOut=3. Busy=1 throughout; InReady=0 until return to IDLE.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 ÷ 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 ÷ 7 → 14. REMU 100 ÷ 7 → 2.
- Fast paths, each with OutValid 1 edge after accept:
  - DIV 5 ÷ 0 → 0xFFFFFFFF; REM 5 ÷ 0 → 5.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: hold OutReady=0 for 10 cycles after OutValid; new request with InValid=1 pending → Result and TagOut stable, InReady=0. Raise OutReady → IDLE next edge, then the pending request is accepted.
- Flush at CALC edge 10 → IDLE next edge, OutValid never rises. rst pulsed low mid-CALC → all outputs 0 immediately; a following MUL 6 × 7 → 42.
